term_write_arbiter: RTL
=======================

Name: term_write_arbiter

Overview:
- Schedules character writes into the Signetics-style video terminal.
- Shares the terminal's single write port between two requesters: the CPU (writes to $D012) and a host injector (boot banner / serial bridge).
- Each requester gets a small FIFO. Characters drain round-robin, one per terminal-ready window, and each is delivered as a one-cycle te/ti strobe.
- Sits between the CPU bus decode and the terminal input (te, ti, tready). It also provides the busy bit the CPU reads back at $D012.

Parameters:
DEPTH, 4, entries per requester FIFO; power of two, minimum 2
AW, 2, FIFO pointer width; must equal log2(DEPTH)

Ports:
clk  input  1  system clock (pixel/CPU clock)
reset  input  1  one clock; reset is asynchronous and active-low
cpu_we  input  1  CPU write strobe for $D012, one cycle per character
cpu_data  input  8  CPU character; bit 7 ignored
cpu_busy  output  1  CPU FIFO full; drives bit 7 of the $D012 read
host_we  input  1  host write strobe, one cycle per character
host_data  input  8  host character; bit 7 ignored
host_full  output  1  host FIFO full
host_ovf  output  1  sticky: a host write was dropped because its FIFO was full
tready  input  1  terminal ready pulse (end of line, not scrolling)
te  output  1  terminal write enable, registered, exactly one cycle per character
ti  output  8  terminal character, registered, bit 7 always 0
last_src  output  1  source of the most recent issue: 0 = CPU, 1 = host
idle  output  1  both FIFOs empty and te low

Behaviour:
- Reset (reset=0, asynchronous): both FIFOs flushed (pointers and counts 0). Outputs te=0, ti=0, last_src=1 (so the CPU wins the first tie), host_ovf=0, cpu_busy=0, host_full=0, idle=1. Any pending or in-flight character is discarded. A write strobe coincident with reset release is ignored.
- Push:
  - On the rising edge with cpu_we=1 and the CPU FIFO not full, store {1'b0, cpu_data[6:0]}. The host side behaves identically.
  - A push to a full FIFO is dropped. On the host side this sets host_ovf, which clears only on reset. On the CPU side the drop is silent; software is expected to poll cpu_busy.
- Full/count:
  - Each FIFO keeps an (AW+1)-bit count. full = (count==DEPTH); empty = (count==0).
  - cpu_busy and host_full are combinational from the count.
- Issue:
  - Evaluated each edge when tready=1, te=0, and at least one FIFO is non-empty.
  - Grant selection:
    - Only one FIFO non-empty: that FIFO is granted.
    - Both non-empty: grant the source opposite last_src (round-robin).
  - On the next edge: te<=1, ti<=head of the granted FIFO, pop that FIFO, last_src<=granted source.
  - te returns to 0 on the following edge unconditionally, so there is never back-to-back te. Latency is 1 cycle from the tready sample to the te output.
- Simultaneous push and pop on the same FIFO in the same cycle:
  - Both take effect and the count is unchanged.
  - A push into a full FIFO in the pop cycle is accepted, because the pop frees the slot.
- Push into an empty FIFO during a tready cycle: the character is not issued that cycle (head not yet valid). It waits for the next tready.
- tready while te=1: ignored. This cannot occur with the terminal's own qualification but must be tolerated.
- Wrap-around: pointers wrap modulo DEPTH. FIFO order is strict per source; there is no ordering guarantee across sources.
- idle = both counts 0 and te=0.

Optional Feature:
TERM_LF_TO_CR_EN
- Defined: a pushed byte whose low 7 bits equal 0x0A is stored as 0x0D, so host text with LF line endings produces new rows.
- Undefined: 0x0A is stored unchanged; the terminal then ignores it as a control code.
- All other bytes are identical in both builds.

Test Plan:
- CPU only: push 0x48 then 0xC5, pulse tready twice (20 cycles apart) -> te high one cycle after each tready; ti=0x48 then 0x45; idle=1 at end.
- Round-robin: preload CPU {0x41,0x42} and host {0x61,0x62}, four tready pulses -> ti order 0x41,0x61,0x42,0x62; last_src toggles 0,1,0,1.
- Full/overflow (DEPTH=4): push 5 host bytes with no tready -> host_full=1 after the 4th, host_ovf=1 after the 5th; drain yields the first 4 bytes only; host_ovf stays 1.
- Push at full coincident with a pop: CPU FIFO full, cpu_we=1 on the pop cycle -> byte accepted, cpu_busy stays 1, and all 5 bytes eventually emitted in order.
- Reset mid-operation: 3 bytes queued, assert reset=0 asynchronously between edges while te=1 -> te=0 and ti=0 immediately; after release, tready produces no te and idle=1.
- TERM_LF_TO_CR_EN build: host pushes 0x0A -> ti=0x0D. Default build: ti=0x0A.

Source files
------------

// File: rtl/term_write_arbiter_if.sv
// Terminal write-arbiter bus: CPU and host write strobes, terminal handshake,
// and status bits. The slave modport is the arbiter; the master modport is
// whatever drives the requesters and the terminal side.
interface term_write_arbiter_if;
    logic       cpu_we;
    logic [7:0] cpu_data;
    logic       cpu_busy;
    logic       host_we;
    logic [7:0] host_data;
    logic       host_full;
    logic       host_ovf;
    logic       tready;
    logic       te;
    logic [7:0] ti;
    logic       last_src;
    logic       idle;

    modport slave (
        input  cpu_we, cpu_data, host_we, host_data, tready,
        output cpu_busy, host_full, host_ovf, te, ti, last_src, idle
    );

    modport master (
        output cpu_we, cpu_data, host_we, host_data, tready,
        input  cpu_busy, host_full, host_ovf, te, ti, last_src, idle
    );
endinterface

// File: rtl/term_write_arbiter.sv
// term_write_arbiter: shares the terminal's single write port between the
// CPU ($D012) and a host injector. Each source has a small FIFO; characters
// drain round-robin, one per terminal-ready window, as a one-cycle te/ti
// strobe.
// Optional build macro: TERM_LF_TO_CR_EN (store pushed LF 0x0A as CR 0x0D).
module term_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    term_write_arbiter_if.slave  bus
);

    typedef enum logic {
        ST_WAIT   = 1'b0,
        ST_STROBE = 1'b1
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    state_t         state_q, state_d;
    logic [7:0]     ti_q;
    logic           last_src_q;
    logic           host_ovf_q;

    logic [6:0]     cpu_mem  [DEPTH];
    logic [6:0]     host_mem [DEPTH];
    logic [AW-1:0]  cpu_wr_ptr, cpu_rd_ptr, host_wr_ptr, host_rd_ptr;
    logic [AW:0]    cpu_cnt, host_cnt;

    logic           cpu_full, cpu_empty, host_full, host_empty;
    logic           issue, grant_host;
    logic           cpu_push, cpu_pop, host_push, host_pop;
    logic [6:0]     cpu_char, host_char;

    // Bit 7 of both data inputs is deliberately discarded.
    logic           unused_bit7;
    assign unused_bit7 = bus.cpu_data[7] ^ bus.host_data[7];

    // Character conversion applied on push; only LF may be rewritten.
    function automatic logic [6:0] map_char(input logic [6:0] c);
`ifdef TERM_LF_TO_CR_EN
        return (c == 7'h0A) ? 7'h0D : c;
`else
        return c;
`endif
    endfunction

    assign cpu_char  = map_char(bus.cpu_data[6:0]);
    assign host_char = map_char(bus.host_data[6:0]);

    assign cpu_full   = (cpu_cnt == FULL_CNT);
    assign cpu_empty  = (cpu_cnt == '0);
    assign host_full  = (host_cnt == FULL_CNT);
    assign host_empty = (host_cnt == '0);

    // Issue decision and round-robin grant; CPU wins a tie when the host went last.
    assign issue      = (state_q == ST_WAIT) && bus.tready && !(cpu_empty && host_empty);
    assign grant_host = !host_empty && (cpu_empty || !last_src_q);
    assign cpu_pop    = issue && !grant_host;
    assign host_pop   = issue && grant_host;

    // A pop in the same cycle frees a slot, so a push at full is accepted then.
    assign cpu_push   = bus.cpu_we  && (!cpu_full  || cpu_pop);
    assign host_push  = bus.host_we && (!host_full || host_pop);

    // FIFO storage writes.
    // NOTE: storage arrays carry no reset; the reset pointers/counts make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (cpu_push)  cpu_mem[cpu_wr_ptr]   <= cpu_char;
        if (host_push) host_mem[host_wr_ptr] <= host_char;
    end

    // CPU FIFO pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_wr_ptr <= '0;
            cpu_rd_ptr <= '0;
            cpu_cnt    <= '0;
        end else begin
            if (cpu_push) cpu_wr_ptr <= cpu_wr_ptr + 1'b1;
            if (cpu_pop)  cpu_rd_ptr <= cpu_rd_ptr + 1'b1;
            case ({cpu_push, cpu_pop})
                2'b10:   cpu_cnt <= cpu_cnt + 1'b1;
                2'b01:   cpu_cnt <= cpu_cnt - 1'b1;
                default: cpu_cnt <= cpu_cnt;
            endcase
        end
    end

    // Host FIFO pointers, occupancy count and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_wr_ptr <= '0;
            host_rd_ptr <= '0;
            host_cnt    <= '0;
            host_ovf_q  <= 1'b0;
        end else begin
            if (host_push) host_wr_ptr <= host_wr_ptr + 1'b1;
            if (host_pop)  host_rd_ptr <= host_rd_ptr + 1'b1;
            case ({host_push, host_pop})
                2'b10:   host_cnt <= host_cnt + 1'b1;
                2'b01:   host_cnt <= host_cnt - 1'b1;
                default: host_cnt <= host_cnt;
            endcase
            if (bus.host_we && !host_push) host_ovf_q <= 1'b1;
        end
    end

    // Strobe state register plus the registered character and source.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_WAIT;
            ti_q       <= 8'h00;
            last_src_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (issue) begin
                ti_q       <= {1'b0, grant_host ? host_mem[host_rd_ptr] : cpu_mem[cpu_rd_ptr]};
                last_src_q <= grant_host;
            end
        end
    end

    // Next-state logic: one strobe cycle per issue, then back to waiting.
    // NOTE: next state gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT:   if (issue) state_d = ST_STROBE;
            ST_STROBE: state_d = ST_WAIT;
            default:   state_d = ST_WAIT;
        endcase
    end

    assign bus.te        = (state_q == ST_STROBE);
    assign bus.ti        = ti_q;
    assign bus.last_src  = last_src_q;
    assign bus.host_ovf  = host_ovf_q;
    assign bus.cpu_busy  = cpu_full;
    assign bus.host_full = host_full;
    assign bus.idle      = cpu_empty && host_empty && (state_q != ST_STROBE);

endmodule
